tdm_demux: RTL and testbench

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_pkg.sv | 18 +
 rtl/tdm_slot_cnt.sv | 35 +++
 rtl/tdm_demux.sv | 125 ++++++++++++
 tb/tb_tdm_demux.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM demultiplexer: framing state and
// the slot-to-dout bit mapping.
package tdm_pkg;

   localparam int DEF_CH   = 4;
   localparam int DEF_BITS = 8;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   // Slot s carries channel s/bits, MSB first within the channel.
   function automatic int slot_bit(input int slot, input int bits);
      return (slot / bits) * bits + (bits - 1 - (slot % bits));
   endfunction

endpackage

// File: rtl/tdm_slot_cnt.sv
// Modulo-F slot counter with clear, load-to-1 and increment; flags the last
// slot of the frame.
module tdm_slot_cnt #(
   parameter int F  = 32,
   parameter int SW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          inc,
   input  logic          load1,
   input  logic          clr,
   output logic [SW-1:0] slot,
   output logic          last
);

   localparam logic [SW-1:0] LAST_SLOT = SW'(F - 1);
   // With a one-slot frame, "slot 1" wraps straight back to 0.
   localparam logic [SW-1:0] ONE_SLOT  = (F > 1) ? SW'(1) : '0;

   assign last = (slot == LAST_SLOT);

   // NOTE: state registers use non-blocking assignments so every flop
   // samples the pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         slot <= '0;
      else if (clr)
         slot <= '0;
      else if (load1)
         slot <= ONE_SLOT;
      else if (inc)
         slot <= last ? '0 : slot + SW'(1);
   end

endmodule

// File: rtl/tdm_demux.sv
// Serial TDM frame demultiplexer: hunts for fsync, assembles CH*BITS slots
// into a shadow frame and publishes only complete frames on dout.
module tdm_demux import tdm_pkg::*; #(
   parameter int CH   = DEF_CH,
   parameter int BITS = DEF_BITS
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             din,
   input  logic             fsync,
   output logic [CH*BITS-1:0] dout,
   output logic             dvalid,
   output logic             locked,
   output logic             sync_err
);

   localparam int F  = CH * BITS;
   localparam int SW = (F > 1) ? $clog2(F) : 1;
   localparam bit SINGLE = (F == 1);

   state_t          state, state_nxt;
   logic [SW-1:0]   slot, wr_slot;
   logic            last;
   logic            store, at_zero, cnt_inc, cnt_load1, cnt_clr, done, err;
   logic [F-1:0]    shadow, shadow_nxt;
   int              wr_idx;

   tdm_slot_cnt #(.F(F), .SW(SW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc),
      .load1 (cnt_load1),
      .clr   (cnt_clr),
      .slot  (slot),
      .last  (last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= HUNT;
      else
         state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      if (en) begin
         case (state)
            HUNT:    if (fsync) state_nxt = LOCKED;
            LOCKED:  if (!fsync && slot == '0) state_nxt = HUNT;
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_comb begin
      store     = 1'b0;
      at_zero   = 1'b0;
      cnt_inc   = 1'b0;
      cnt_load1 = 1'b0;
      cnt_clr   = 1'b0;
      done      = 1'b0;
      err       = 1'b0;
      if (en) begin
         case (state)
            HUNT: begin
               if (fsync) begin
                  store     = 1'b1;
                  at_zero   = 1'b1;
                  cnt_load1 = 1'b1;
                  done      = SINGLE;
               end
            end
            LOCKED: begin
               if (fsync && slot != '0) begin
                  // Early marker: restart the frame on this sample.
                  err       = 1'b1;
                  store     = 1'b1;
                  at_zero   = 1'b1;
                  cnt_load1 = 1'b1;
               end else if (!fsync && slot == '0) begin
                  err     = 1'b1;
                  cnt_clr = 1'b1;
               end else begin
                  store   = 1'b1;
                  cnt_inc = 1'b1;
                  done    = last;
               end
            end
            default: ;
         endcase
      end
   end

   assign wr_slot = at_zero ? '0 : slot;
   assign wr_idx  = slot_bit(int'(wr_slot), BITS);

   always_comb begin
      shadow_nxt = shadow;
      for (int i = 0; i < F; i++)
         if (store && i == wr_idx) shadow_nxt[i] = din;
   end

   // NOTE: the shadow frame is a flop vector rather than a RAM, so it is
   // cleared by reset like the rest of the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow   <= '0;
         dout     <= '0;
         dvalid   <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         shadow   <= shadow_nxt;
         dvalid   <= done;
         sync_err <= err;
         if (done) dout <= shadow_nxt;
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (CH=4, BITS=8): directed framing
// scenarios plus a randomized run against a queue-based frame model.
module tb_tdm_demux;

   localparam int CH   = 4;
   localparam int BITS = 8;
   localparam int F    = CH * BITS;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en, din, fsync;
   logic [F-1:0]  dout;
   logic          dvalid, locked, sync_err;

   tdm_demux #(.CH(CH), .BITS(BITS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .din      (din),
      .fsync    (fsync),
      .dout     (dout),
      .dvalid   (dvalid),
      .locked   (locked),
      .sync_err (sync_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: bits collected since the frame marker.
   bit           m_locked;
   bit           m_q[$];
   logic [F-1:0] m_dout;
   bit           m_dv, m_err;

   // Observations of the DUT accumulated by step().
   int           cyc, dv_cnt, err_cnt, last_dv_cyc;
   logic [F-1:0] last_dout;

   function automatic logic [F-1:0] assemble();
      logic [F-1:0]    w;
      logic [BITS-1:0] ch;
      w = '0;
      for (int k = 0; k < CH; k++) begin
         ch = '0;
         for (int b = 0; b < BITS; b++) ch = {ch[BITS-2:0], m_q[k*BITS+b]};
         w[k*BITS +: BITS] = ch;
      end
      return w;
   endfunction

   task automatic model_reset();
      m_locked = 0;
      m_q.delete();
      m_dout = '0;
      m_dv = 0;
      m_err = 0;
   endtask

   task automatic clear_obs();
      dv_cnt = 0;
      err_cnt = 0;
      last_dv_cyc = -1;
   endtask

   task automatic step(input bit e, input bit f, input bit d);
      en = e;
      fsync = f;
      din = d;
      @(posedge clk);
      m_dv = 0;
      m_err = 0;
      if (e) begin
         if (!m_locked) begin
            if (f) begin
               m_q = {d};
               m_locked = 1;
            end
         end else if (f && m_q.size() != 0) begin
            m_err = 1;
            m_q = {d};
         end else if (!f && m_q.size() == 0) begin
            m_err = 1;
            m_locked = 0;
         end else begin
            m_q.push_back(d);
         end
         if (m_locked && m_q.size() == F) begin
            m_dout = assemble();
            m_dv = 1;
            m_q.delete();
         end
      end
      #1;
      cyc++;
      if (dvalid === 1'b1) begin
         dv_cnt++;
         last_dv_cyc = cyc;
         last_dout = dout;
      end
      if (sync_err === 1'b1) err_cnt++;
   endtask

   // Serialize slots first..lst of word w; fs0 marks slot 0, gap inserts
   // a disabled cycle with random din/fsync after every enabled sample.
   task automatic send_slots(input logic [F-1:0] w, input int first, input int lst,
                             input bit fs0, input bit gap);
      logic [F-1:0] t;
      for (int s = first; s <= lst; s++) begin
         t = w >> ((s / BITS) * BITS + BITS - 1 - (s % BITS));
         step(1'b1, fs0 && (s == 0), t[0]);
         if (gap) step(1'b0, 1'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if ({dout, dvalid, locked, sync_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got dout=%h dv=%b lk=%b err=%b, want all 0",
                  dout, dvalid, locked, sync_err);
      end
      #10 rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b1);
      n_checks++;
      if (locked !== 1'b0 || sync_err !== 1'b0) begin
         n_fail++;
         $display("FAIL hunt_no_fsync: got lk=%b err=%b, want 0 0", locked, sync_err);
      end
   endtask

   task automatic test_single_frame();
      int c0;
      clear_obs();
      c0 = cyc;
      send_slots(32'h01FF3CA5, 0, F - 1, 1'b1, 1'b0);
      n_checks++;
      if (dv_cnt != 1 || last_dv_cyc - c0 != F) begin
         n_fail++;
         $display("FAIL single_dvalid: got %0d pulses at +%0d, want 1 at +%0d",
                  dv_cnt, last_dv_cyc - c0, F);
      end
      n_checks++;
      if (dout !== 32'h01FF3CA5 || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL single_dout: got %h lk=%b, want 01ff3ca5 lk=1", dout, locked);
      end
   endtask

   task automatic test_back_to_back();
      int c0, first_dv;
      clear_obs();
      c0 = cyc;
      send_slots(32'h11223344, 0, F - 1, 1'b1, 1'b0);
      first_dv = last_dv_cyc;
      n_checks++;
      if (last_dout !== 32'h11223344) begin
         n_fail++;
         $display("FAIL b2b_first: got %h, want 11223344", last_dout);
      end
      send_slots(32'hDEADBEEF, 0, F - 1, 1'b1, 1'b0);
      n_checks++;
      if (last_dout !== 32'hDEADBEEF || dout !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL b2b_second: got %h, want deadbeef", last_dout);
      end
      n_checks++;
      if (dv_cnt != 2 || err_cnt != 0 || last_dv_cyc - first_dv != F || first_dv - c0 != F) begin
         n_fail++;
         $display("FAIL b2b_timing: got %0d pulses %0d errs spacing %0d, want 2 0 %0d",
                  dv_cnt, err_cnt, last_dv_cyc - first_dv, F);
      end
   endtask

   task automatic test_en_toggle();
      int c0;
      clear_obs();
      c0 = cyc;
      send_slots(32'h01FF3CA5, 0, F - 1, 1'b1, 1'b1);
      n_checks++;
      if (dv_cnt != 1 || last_dv_cyc - c0 != 2 * F - 1 || err_cnt != 0) begin
         n_fail++;
         $display("FAIL en_toggle_dvalid: got %0d pulses at +%0d errs %0d, want 1 at +%0d 0",
                  dv_cnt, last_dv_cyc - c0, err_cnt, 2 * F - 1);
      end
      n_checks++;
      if (dout !== 32'h01FF3CA5) begin
         n_fail++;
         $display("FAIL en_toggle_dout: got %h, want 01ff3ca5", dout);
      end
   endtask

   task automatic test_fsync_early();
      int c0;
      clear_obs();
      c0 = cyc;
      send_slots(32'hCAFEF00D, 0, 9, 1'b1, 1'b0);
      send_slots(32'h5A5AC3C3, 0, F - 1, 1'b1, 1'b0);
      n_checks++;
      if (err_cnt != 1 || dv_cnt != 1 || last_dv_cyc - c0 != 10 + F) begin
         n_fail++;
         $display("FAIL early_fsync: got errs %0d pulses %0d at +%0d, want 1 1 at +%0d",
                  err_cnt, dv_cnt, last_dv_cyc - c0, 10 + F);
      end
      n_checks++;
      if (dout !== 32'h5A5AC3C3 || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL early_fsync_dout: got %h lk=%b, want 5a5ac3c3 lk=1", dout, locked);
      end
   endtask

   task automatic test_fsync_missing();
      clear_obs();
      send_slots(32'h87654321, 0, 0, 1'b0, 1'b0);
      n_checks++;
      if (err_cnt != 1 || sync_err !== 1'b1 || locked !== 1'b0) begin
         n_fail++;
         $display("FAIL missing_fsync: got errs %0d err=%b lk=%b, want 1 1 0",
                  err_cnt, sync_err, locked);
      end
      send_slots(32'h87654321, 1, F - 1, 1'b0, 1'b0);
      n_checks++;
      if (dout !== 32'h5A5AC3C3 || dv_cnt != 0 || err_cnt != 1) begin
         n_fail++;
         $display("FAIL missing_hold: got %h pulses %0d errs %0d, want 5a5ac3c3 0 1",
                  dout, dv_cnt, err_cnt);
      end
      send_slots(32'h0F1E2D3C, 0, F - 1, 1'b1, 1'b0);
      n_checks++;
      if (dout !== 32'h0F1E2D3C || dv_cnt != 1 || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL relock: got %h pulses %0d lk=%b, want 0f1e2d3c 1 1",
                  dout, dv_cnt, locked);
      end
   endtask

   task automatic test_reset_mid();
      send_slots(32'h13579BDF, 0, 19, 1'b1, 1'b0);
      rst_n = 1'b0;
      #1;
      model_reset();
      n_checks++;
      if ({dout, dvalid, locked, sync_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid: got dout=%h dv=%b lk=%b err=%b, want all 0",
                  dout, dvalid, locked, sync_err);
      end
      #20 rst_n = 1'b1;
      clear_obs();
      send_slots(32'h13579BDF, 20, F - 1, 1'b1, 1'b0);
      n_checks++;
      if (dv_cnt != 0 || err_cnt != 0 || dout !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_tail: got pulses %0d errs %0d dout %h, want 0 0 0",
                  dv_cnt, err_cnt, dout);
      end
      send_slots(32'h2468ACE0, 0, F - 1, 1'b1, 1'b0);
      n_checks++;
      if (dv_cnt != 1 || dout !== 32'h2468ACE0) begin
         n_fail++;
         $display("FAIL reset_mid_frame: got pulses %0d dout %h, want 1 2468ace0",
                  dv_cnt, dout);
      end
   endtask

   task automatic test_random();
      bit e, f;
      for (int i = 0; i < 1500; i++) begin
         e = ($urandom_range(0, 9) < 7);
         if (!m_locked)       f = ($urandom_range(0, 3) == 0);
         else if (m_q.size() == 0) f = ($urandom_range(0, 19) != 0);
         else                 f = ($urandom_range(0, 59) == 0);
         step(e, f, 1'($urandom));
         n_checks++;
         if ({dvalid, sync_err, locked, dout} !== {m_dv, m_err, m_locked, m_dout}) begin
            n_fail++;
            $display("FAIL random[%0d]: got dv=%b err=%b lk=%b dout=%h, want dv=%b err=%b lk=%b dout=%h",
                     i, dvalid, sync_err, locked, dout, m_dv, m_err, m_locked, m_dout);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b0;
      fsync = 1'b0;
      din = 1'b0;
      cyc = 0;
      last_dout = '0;
      model_reset();
      clear_obs();
      #2;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_en_toggle();
      test_fsync_early();
      test_fsync_missing();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
